// File: rtl/simon_pkg.sv
// Shared types and constants for the sequence-memory game engine.
package simon_pkg;

    localparam int unsigned LFSR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_WIN,
        S_LOSE
    } state_t;

    typedef enum logic {
        CLASSIC = 1'b0,
        REVERSE = 1'b1
    } mode_t;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
    // Taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK     = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; a zero seed falls back to the default.
module lfsr16
    import simon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAP_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            value <= {value[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/simon_engine.sv
// Sequence-memory game engine: grows a random key sequence, plays it back,
// checks the player's entries (classic or reverse order) and keeps score.
module simon_engine
    import simon_pkg::*;
#(
    parameter  int unsigned NUM_KEYS       = 4,
    parameter  int unsigned MAX_LEN        = 16,
    parameter  int unsigned SHOW_CYCLES    = 8,
    parameter  int unsigned GAP_CYCLES     = 2,
    parameter  int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned KW             = $clog2(NUM_KEYS),
    localparam int unsigned LW             = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [LFSR_W-1:0] seed,
    input  logic              key_valid,
    input  logic [KW-1:0]     key_idx,
    output logic              show_valid,
    output logic [KW-1:0]     show_idx,
    output logic              input_ready,
    output logic [LW-1:0]     score,
    output logic              game_over,
    output logic              win
);

    localparam int unsigned AW      = $clog2(MAX_LEN);
    localparam int unsigned CNT_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (CNT_SG > TIMEOUT_CYCLES) ? CNT_SG : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    state_t            state;
    mode_t             mode_q;
    logic [LW-1:0]     len;
    logic [LW-1:0]     idx;
    logic [LW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic [KW-1:0]     mem [MAX_LEN];

    logic [LFSR_W-1:0] lfsr_val;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              unused_lfsr_bits;
    logic [KW-1:0]     exp_key;
    logic              last_key;

    assign lfsr_load = !abort && start &&
                       (state == S_IDLE || state == S_WIN || state == S_LOSE);
    assign lfsr_step = !abort && (state == S_ADD);
    assign unused_lfsr_bits = ^lfsr_val[LFSR_W-1:KW];

    assign exp_key  = mem[AW'(ptr)];
    assign last_key = (mode_q == REVERSE) ? (ptr == '0) : (ptr == len - LW'(1));

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // Pattern memory: never cleared, only entries below len are read
    always_ff @(posedge clk) begin
        if (state == S_ADD) begin
            mem[AW'(len)] <= lfsr_val[KW-1:0];
        end
    end

    // Game FSM; outputs are registered alongside each transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= CLASSIC;
            len         <= '0;
            idx         <= '0;
            ptr         <= '0;
            cnt         <= '0;
            score       <= '0;
            show_valid  <= 1'b0;
            show_idx    <= '0;
            input_ready <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else if (abort) begin
            state       <= S_IDLE;
            len         <= '0;
            idx         <= '0;
            ptr         <= '0;
            cnt         <= '0;
            score       <= '0;
            show_valid  <= 1'b0;
            show_idx    <= '0;
            input_ready <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        mode_q    <= mode_t'(mode);
                        len       <= '0;
                        idx       <= '0;
                        ptr       <= '0;
                        cnt       <= '0;
                        score     <= '0;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                        state     <= S_ADD;
                    end
                end
                S_ADD: begin
                    len        <= len + LW'(1);
                    idx        <= '0;
                    cnt        <= '0;
                    show_valid <= 1'b1;
                    // mem[0] is still being written on the very first round
                    show_idx   <= (len == '0) ? lfsr_val[KW-1:0] : mem[0];
                    state      <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (cnt == CW'(SHOW_CYCLES - 1)) begin
                        cnt        <= '0;
                        show_valid <= 1'b0;
                        show_idx   <= '0;
                        state      <= S_SHOW_OFF;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (idx == len - LW'(1)) begin
                            ptr         <= (mode_q == REVERSE) ? len - LW'(1) : '0;
                            input_ready <= 1'b1;
                            state       <= S_INPUT;
                        end else begin
                            idx        <= idx + LW'(1);
                            show_valid <= 1'b1;
                            show_idx   <= mem[AW'(idx + LW'(1))];
                            state      <= S_SHOW_ON;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_INPUT: begin
                    // A key arriving on the timeout cycle takes precedence
                    if (key_valid) begin
                        cnt <= '0;
                        if (key_idx != exp_key) begin
                            input_ready <= 1'b0;
                            game_over   <= 1'b1;
                            state       <= S_LOSE;
                        end else if (last_key) begin
                            score       <= len;
                            input_ready <= 1'b0;
                            if (len == LW'(MAX_LEN)) begin
                                game_over <= 1'b1;
                                win       <= 1'b1;
                                state     <= S_WIN;
                            end else begin
                                state <= S_ADD;
                            end
                        end else begin
                            ptr <= (mode_q == REVERSE) ? ptr - LW'(1) : ptr + LW'(1);
                        end
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        cnt         <= '0;
                        input_ready <= 1'b0;
                        game_over   <= 1'b1;
                        state       <= S_LOSE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// Bench for simon_engine: scripted corner cases plus a table of whole games.
`timescale 1ns/1ps
module tb_simon_engine;

    localparam int unsigned NK = 4;
    localparam int unsigned ML = 4;
    localparam int unsigned SC = 2;
    localparam int unsigned GC = 1;
    localparam int unsigned TO = 5;
    localparam int unsigned KW = 2;
    localparam int unsigned LW = 3;
    localparam int unsigned NV = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          mode;
    logic [15:0]   seed;
    logic          key_valid;
    logic [KW-1:0] key_idx;
    logic          show_valid;
    logic [KW-1:0] show_idx;
    logic          input_ready;
    logic [LW-1:0] score;
    logic          game_over;
    logic          win;

    always #5 clk = ~clk;

    simon_engine #(
        .NUM_KEYS       (NK),
        .MAX_LEN        (ML),
        .SHOW_CYCLES    (SC),
        .GAP_CYCLES     (GC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .seed        (seed),
        .key_valid   (key_valid),
        .key_idx     (key_idx),
        .show_valid  (show_valid),
        .show_idx    (show_idx),
        .input_ready (input_ready),
        .score       (score),
        .game_over   (game_over),
        .win         (win)
    );

    typedef struct {
        logic [15:0] seed;
        logic        rev;
        int          fail_round;   // 0 = play to the end
        int          fail_kind;    // 1 wrong key, 2 classic order in reverse, 3 timeout
        int          exp_score;
        logic        exp_win;
    } game_vec_t;

    game_vec_t     vecs [NV];
    logic [KW-1:0] seq [ML];
    logic [KW-1:0] exp_q [$];
    logic          cur_rev;
    int            n_checks = 0;
    int            n_errs   = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_seq(input logic [15:0] s);
        logic [15:0] v;
        v = (s == 16'h0000) ? 16'hACE1 : s;
        for (int i = 0; i < int'(ML); i++) begin
            seq[i] = v[1:0];
            v      = lfsr_next(v);
        end
    endtask

    task automatic start_game(input logic [15:0] s, input logic rev);
        seed    = s;
        mode    = rev;
        cur_rev = rev;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        gen_seq(s);
        exp_q.delete();
        exp_q.push_back(seq[0]);
    endtask

    task automatic enter(input logic [KW-1:0] k);
        key_valid = 1'b1;
        key_idx   = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int b;
        for (b = 0; b < 100 && !input_ready; b++) tick();
        if (!input_ready) fail("wait_ready_timeout");
    endtask

    // Pops one expected lamp per rising show_valid until the engine asks for input
    task automatic watch_playback();
        int on_len;
        int b;
        logic prev;
        on_len = 0;
        prev   = 1'b0;
        for (b = 0; b < 200 && !input_ready; b++) begin
            tick();
            if (show_valid && !prev) begin
                if (exp_q.size() == 0) fail("lamp_extra");
                else check("lamp_idx", 32'(show_idx), 32'(exp_q.pop_front()));
                on_len = 0;
            end
            if (show_valid) on_len++;
            if (!show_valid && prev) check("lamp_len", 32'(on_len), 32'(SC));
            prev = show_valid;
        end
        if (!input_ready) fail("playback_timeout");
        check("lamps_left", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic play_round(input int len);
        for (int i = 0; i < len; i++) begin
            enter(cur_rev ? seq[len-1-i] : seq[i]);
        end
    endtask

    task automatic do_fail(input int kind, input int len);
        logic [KW-1:0] e;
        case (kind)
            1: begin
                e = cur_rev ? seq[len-1] : seq[0];
                enter(e + 2'd1);
            end
            2: enter(seq[0]);
            default: begin
                repeat (TO - 1) tick();
                check("pre_timeout_ready", 32'(input_ready), 32'(1));
                tick();
            end
        endcase
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_show_valid"},  32'(show_valid),  32'(0));
        check({tag, "_show_idx"},    32'(show_idx),    32'(0));
        check({tag, "_input_ready"}, 32'(input_ready), 32'(0));
        check({tag, "_score"},       32'(score),       32'(0));
        check({tag, "_game_over"},   32'(game_over),   32'(0));
        check({tag, "_win"},         32'(win),         32'(0));
    endtask

    initial begin
        vecs[0] = '{16'h0001, 1'b0, 0, 0, 4, 1'b1};
        vecs[1] = '{16'h0001, 1'b0, 1, 1, 0, 1'b0};
        vecs[2] = '{16'h0001, 1'b1, 0, 0, 4, 1'b1};
        vecs[3] = '{16'h0001, 1'b1, 2, 2, 1, 1'b0};
        vecs[4] = '{16'h0000, 1'b0, 0, 0, 4, 1'b1};
        vecs[5] = '{16'hACE1, 1'b0, 0, 0, 4, 1'b1};
        vecs[6] = '{16'h0001, 1'b0, 2, 3, 1, 1'b0};
        vecs[7] = '{16'h1234, 1'b1, 3, 1, 2, 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        seed      = 16'h0000;
        key_valid = 1'b0;
        key_idx   = '0;
        cur_rev   = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // First lamp timing with seed 1, then a correct key on the last timeout cycle
        start_game(16'h0001, 1'b0);
        check("add_dark", 32'(show_valid), 32'(0));
        tick();
        check("lamp1_on", 32'(show_valid), 32'(1));
        check("lamp1_idx", 32'(show_idx), 32'(1));
        tick();
        check("lamp1_hold", 32'(show_valid), 32'(1));
        tick();
        check("gap_dark", 32'(show_valid), 32'(0));
        check("gap_idx", 32'(show_idx), 32'(0));
        tick();
        check("ready_after_gap", 32'(input_ready), 32'(1));
        repeat (TO - 1) tick();
        check("tie_still_ready", 32'(input_ready), 32'(1));
        enter(seq[0]);
        check("tie_key_ready", 32'(input_ready), 32'(0));
        check("tie_key_score", 32'(score), 32'(1));
        check("tie_key_go", 32'(game_over), 32'(0));

        // Key and start during playback are dropped
        tick();
        key_valid = 1'b1;
        key_idx   = seq[0];
        start     = 1'b1;
        seed      = 16'hACE1;
        tick();
        key_valid = 1'b0;
        start     = 1'b0;
        check("show_key_lamp", 32'(show_valid), 32'(1));
        check("show_key_ready", 32'(input_ready), 32'(0));
        check("show_key_go", 32'(game_over), 32'(0));
        wait_ready();
        enter(seq[0]);
        enter(seq[1]);
        check("round2_score", 32'(score), 32'(2));

        // Abort during playback beats a simultaneous start and clears score
        tick();
        check("r3_lamp", 32'(show_valid), 32'(1));
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        repeat (3) tick();
        check("abort_stays_idle", 32'(show_valid), 32'(0));

        // Reset mid-INPUT clears outputs without waiting for a clock edge
        start_game(16'h0001, 1'b0);
        watch_playback();
        enter(seq[0]);
        exp_q.push_back(seq[0]);
        exp_q.push_back(seq[1]);
        watch_playback();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(input_ready), 32'(0));

        // Whole games from the table
        for (int r = 0; r < int'(NV); r++) begin
            start_game(vecs[r].seed, vecs[r].rev);
            for (int len = 1; len <= int'(ML); len++) begin
                watch_playback();
                if (len == vecs[r].fail_round) begin
                    do_fail(vecs[r].fail_kind, len);
                    break;
                end
                play_round(len);
                check($sformatf("row%0d_score_r%0d", r, len), 32'(score), 32'(len));
                if (len < int'(ML)) begin
                    check($sformatf("row%0d_alive_r%0d", r, len), 32'(game_over), 32'(0));
                    for (int i = 0; i <= len; i++) exp_q.push_back(seq[i]);
                end
            end
            check($sformatf("row%0d_final_score", r), 32'(score), 32'(vecs[r].exp_score));
            check($sformatf("row%0d_win", r), 32'(win), 32'(vecs[r].exp_win));
            check($sformatf("row%0d_game_over", r), 32'(game_over), 32'(1));
            check($sformatf("row%0d_ready", r), 32'(input_ready), 32'(0));
            tick();
            check($sformatf("row%0d_score_held", r), 32'(score), 32'(vecs[r].exp_score));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/simon_engine.md
# simon_engine

Parametrised sequence-memory game engine. It generates a growing pseudo-random key sequence, plays it back to the display, collects and checks the player's key presses, and tracks score. It sits between the button debouncer/encoder (key inputs) and the LED/display driver (show outputs), replacing the fixed-width classic-mode controller. It adds a configurable key count and depth, a reverse-entry mode, an input timeout and a win condition.

## Interface
- NUM_KEYS, 4: number of player keys/lamps; power of two, 2..16.
- MAX_LEN, 16: maximum sequence length and win threshold; 2..256.
- SHOW_CYCLES, 8: cycles each element is lit during playback; ≥1.
- GAP_CYCLES, 2: dark cycles after each lit element; ≥1.
- TIMEOUT_CYCLES, 1000: idle cycles allowed between presses in INPUT; ≥1.
- KW = $clog2(NUM_KEYS), LW = $clog2(MAX_LEN+1): derived localparams.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- start  in  1  single-cycle pulse; begins a new game.
- abort  in  1  single-cycle pulse; returns to IDLE from any state.
- mode  in  1  0 = CLASSIC (enter in shown order), 1 = REVERSE (enter last-to-first); sampled on start only.
- seed  in  16  LFSR seed; sampled on start; 0 is replaced by 16'hACE1.
- key_valid  in  1  single-cycle key press strobe.
- key_idx  in  KW  pressed key.
- show_valid  out  1  lamp on.
- show_idx  out  KW  lamp to light; 0 when show_valid=0.
- input_ready  out  1  engine accepting key presses.
- score  out  LW  completed rounds.
- game_over  out  1  in WIN or LOSE.
- win  out  1  in WIN.

Clocking and reset are fixed: one clock; reset is asynchronous and active-low (ports clk, rst_n).

## Operation
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- IDLE: all outputs 0. On start, latch mode, load the LFSR with the seed, set len=0 and score=0, then go to ADD.
- ADD (1 cycle):
  - mem[len] <= lfsr[KW-1:0]; len <= len+1; LFSR advances one step.
  - idx=0, then go to SHOW_ON.
- SHOW_ON: show_valid=1, show_idx=mem[idx], held for SHOW_CYCLES cycles, then go to SHOW_OFF.
- SHOW_OFF: dark for GAP_CYCLES cycles.
  - If idx==len-1, go to INPUT with ptr=0 (CLASSIC) or ptr=len-1 (REVERSE).
  - Else idx++ and go to SHOW_ON.
- INPUT: input_ready=1; the timeout counter runs. On key_valid:
  - key_idx != mem[ptr]: go to LOSE.
  - Match, not last: step ptr (+1 CLASSIC, −1 REVERSE); the timeout counter clears.
  - Match, last: score <= len. If len==MAX_LEN go to WIN, else go to ADD.
- Timeout: TIMEOUT_CYCLES consecutive cycles in INPUT without key_valid sends the engine to LOSE.
- WIN/LOSE: game_over=1; win=1 only in WIN. score is held. start begins a new game (same as from IDLE).
- Ignored inputs:
  - key_valid outside INPUT is dropped (not queued).
  - start is ignored in ADD, SHOW_ON, SHOW_OFF and INPUT.
- abort: goes to IDLE next cycle from any state and clears score. abort has priority over start and key_valid.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.

## Timing
- Reset: state IDLE; every output 0; len, idx, ptr and counters 0; the LFSR holds 16'hACE1.
- All outputs are registered or decoded from the state register; there is no combinational path from input to output.
- start → ADD on the next edge. ADD → SHOW_ON one cycle later, so the first lamp appears 2 cycles after start.
- Playback of a length-L round takes L×(SHOW_CYCLES+GAP_CYCLES) cycles.
- A key is evaluated on the edge where key_valid=1. The resulting state and score update are visible the next cycle.
- If key_valid arrives in the cycle the timeout expires, the key wins.
- The mem array is not cleared on reset or start; only entries below len are ever read.

## Structure
- simon_pkg holds state_t, mode_t (CLASSIC, REVERSE), LFSR_DEFAULT_SEED=16'hACE1 and the LFSR tap mask.
- Sub-module lfsr16 (clk, rst_n, load, seed, step → value) handles seed load and stepping.
- Pattern memory is an inline register array of MAX_LEN×KW bits.

## Test plan
Common bench parameters: NUM_KEYS=4, MAX_LEN=4, SHOW=2, GAP=1, TIMEOUT=5. Rows below use seed=16'h0001.
- Reset, then start, seed 16'h0001:
  - One lamp shows for 2 cycles, show_idx=lfsr[1:0] of the seed state, followed by 1 dark cycle, then input_ready=1.
- Play all 4 rounds correctly in CLASSIC: score reaches 1,2,3,4; then win=1 and game_over=1; score stays 4.
- REVERSE round 2 (seq a,b): entering b,a advances to round 3; entering a,b gives LOSE with score=1.
- Wrong key in round 1: LOSE, game_over=1, win=0, score=0.
- Timeout and tie:
  - No key for 5 cycles in INPUT gives LOSE.
  - A correct key at exactly cycle 5 is accepted instead.
- Inputs at odd times:
  - key_valid during SHOW_ON is ignored (no state change).
  - abort mid-SHOW goes to IDLE with all outputs 0.
  - rst_n asserted mid-INPUT clears everything immediately.
  - seed=0 behaves identically to seed 16'hACE1.
